gpr_file: RTL and testbench



---
 rtl/gpr_pkg.sv | 7 +
 rtl/gpr_file_if.sv | 19 +
 rtl/gpr_word.sv | 18 +
 rtl/gpr_file.sv | 50 +++++
 tb/tb_gpr_file.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/gpr_pkg.sv
// Shared constants and word type for the general-purpose register file.
package gpr_pkg;
  localparam int GPR_N    = 32;
  localparam int GPR_NREG = 32;

  typedef logic [GPR_N-1:0] gpr_word_t;
endpackage

// File: rtl/gpr_file_if.sv
// Register-file port bundle. The address is shared by the read and write-back stages.
interface gpr_file_if
  import gpr_pkg::*;
#(
  parameter int N    = GPR_N,
  parameter int Nreg = GPR_NREG
);
  localparam int K = $clog2(Nreg);

  // No handshake: wren qualifies a write for exactly the edge it is sampled on,
  // and q is a combinational function of address and current contents.
  logic         wren;
  logic [K-1:0] address;
  logic [N-1:0] d;
  logic [N-1:0] q;

  modport master (output wren, output address, output d, input q);
  modport slave  (input wren, input address, input d, output q);
endinterface

// File: rtl/gpr_word.sv
// One N-bit register with synchronous active-high reset and write enable.
module gpr_word #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/gpr_file.sv
// Register file: Nreg x N words, combinational read, synchronous write.
// Define GPR_R0_ZERO_EN to hardwire register 0 to zero (no storage allocated).
module gpr_file
  import gpr_pkg::*;
#(
  parameter int N    = GPR_N,
  parameter int Nreg = GPR_NREG
) (
  input logic        clk,
  input logic        rst,
  gpr_file_if.slave  bus
);
  localparam int K = $clog2(Nreg);

  logic [N-1:0] regs [Nreg];

  for (genvar i = 0; i < Nreg; i++) begin : g_reg
`ifdef GPR_R0_ZERO_EN
    if (i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_word
      gpr_word #(.N(N)) u_word (
        .clk (clk),
        .rst (rst),
        .en  (bus.wren && (bus.address == K'(i))),
        .d   (bus.d),
        .q   (regs[i])
      );
    end
`else
    gpr_word #(.N(N)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (bus.wren && (bus.address == K'(i))),
      .d   (bus.d),
      .q   (regs[i])
    );
`endif
  end

  // Addresses with no matching register (non-power-of-two Nreg) fall through to 0.
  always_comb begin
    bus.q = '0;
    for (int i = 0; i < Nreg; i++) begin
      if (bus.address == K'(i)) begin
        bus.q = regs[i];
      end
    end
  end
endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file; honours GPR_R0_ZERO_EN when defined.
module tb_gpr_file;
  import gpr_pkg::*;

  logic clk = 1'b0;
  logic rst;

  gpr_file_if #(.N(GPR_N), .Nreg(GPR_NREG)) bus ();

  gpr_file #(.N(GPR_N), .Nreg(GPR_NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  gpr_word_t model [GPR_NREG];
  gpr_word_t exp_q [$];
  int        chk_cnt  = 0;
  int        pass_cnt = 0;

`ifdef GPR_R0_ZERO_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  task automatic check(input string tag, input gpr_word_t got, input gpr_word_t want);
    chk_cnt++;
    if (got === want) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < GPR_NREG; i++) model[i] = '0;
  endtask

  task automatic write_reg(input logic [4:0] a, input gpr_word_t w);
    @(negedge clk);
    bus.wren    = 1'b1;
    bus.address = a;
    bus.d       = w;
    @(posedge clk);
    #1;
    bus.wren = 1'b0;
    if (!(ZERO_R0 && a == 5'd0)) model[a] = w;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a);
    bus.address = a;
    exp_q.push_back(model[a]);
    #1;
    check(tag, bus.q, exp_q.pop_front());
  endtask

  initial begin
    rst         = 1'b1;
    bus.wren    = 1'b0;
    bus.address = '0;
    bus.d       = '0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < 32; a++) read_chk($sformatf("reset_a%0d", a), 5'(a));

    // Multi-write
    write_reg(5'd5, 32'hDEADBEEF);
    write_reg(5'd10, 32'hCAFEBABE);
    write_reg(5'd31, 32'h12345678);
    read_chk("mw_a5", 5'd5);
    read_chk("mw_a10", 5'd10);
    read_chk("mw_a31", 5'd31);
    read_chk("mw_a6_untouched", 5'd6);
    check("mw_a5_const", model[5], 32'hDEADBEEF);

    // No write with wren low
    @(negedge clk);
    bus.address = 5'd5;
    bus.d       = 32'hAAAAAAAA;
    bus.wren    = 1'b0;
    @(posedge clk);
    #1;
    check("nowrite_a5", bus.q, 32'hDEADBEEF);

    // Same-cycle read/write: old value before edge, new value after
    @(negedge clk);
    bus.address = 5'd7;
    bus.d       = 32'h0000FFFF;
    bus.wren    = 1'b1;
    #1;
    check("rw_before_edge", bus.q, 32'h00000000);
    @(posedge clk);
    #1;
    bus.wren = 1'b0;
    check("rw_after_edge", bus.q, 32'h0000FFFF);
    model[7] = 32'h0000FFFF;

    // Zero register behaviour
    write_reg(5'd0, 32'hFFFFFFFF);
    bus.address = 5'd0;
    #1;
    check("r0_write", bus.q, ZERO_R0 ? 32'h00000000 : 32'hFFFFFFFF);

    // Held wren writes every cycle: last value wins
    @(negedge clk);
    bus.wren    = 1'b1;
    bus.address = 5'd12;
    bus.d       = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    bus.d       = 32'h22222222;
    @(posedge clk);
    #1;
    bus.wren  = 1'b0;
    model[12] = 32'h22222222;
    read_chk("held_wren_a12", 5'd12);

    // Random writes with readback of the full file
    for (int n = 0; n < 40; n++) begin
      write_reg(5'($urandom_range(0, 31)), gpr_word_t'($urandom));
    end
    for (int a = 0; a < 32; a++) read_chk($sformatf("rand_a%0d", a), 5'(a));

    // Reset has priority over a simultaneous write
    @(negedge clk);
    rst         = 1'b1;
    bus.wren    = 1'b1;
    bus.address = 5'd10;
    bus.d       = 32'h55555555;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.wren = 1'b0;
    model_reset();
    for (int a = 0; a < 32; a++) read_chk($sformatf("rstprio_a%0d", a), 5'(a));

    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
